// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads a 1-cycle-latency ROM, hands instructions to decode.
// Latency: ROM word is presented on Instruction the cycle after its fetch; redirects cost one bubble.
// Backpressure: stall freezes all state and disables the ROM; the presented word is kept locally.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          IMEM_AW   = 14,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               Branch,
    input  logic               Zero,
    input  logic               Jal,
    input  logic               Jr,
    input  logic [31:0]        Imm32,
    input  logic [31:0]        Read_data_1,
    output logic               imem_en,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [31:0]        Instruction,
    output logic [31:0]        instr_pc,
    output logic               instr_valid,
    output logic [31:0]        link_addr,
    output logic               misalign
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc, fetch_pc_nxt;
    logic [31:0] pc_q, pc_nxt;
    logic        vld_q, vld_nxt;
    logic        mis_q, mis_nxt;
    // held_sel: previous cycle was stalled, so the ROM output can no longer be trusted
    logic        held_sel;
    logic [31:0] held_dat;

    logic        redirect;
    logic [31:0] jr_sum;
    logic [31:0] rel_sum;
    logic [31:0] raw_target;
    logic [31:0] target;

    // Redirect target: jalr base wins over pc-relative forms; low two bits are dropped
    always_comb begin
        jr_sum     = Read_data_1 + Imm32;
        rel_sum    = pc_q + Imm32;
        raw_target = Jr ? (jr_sum & ~32'h1) : rel_sum;
        target     = raw_target & ~32'h3;
        redirect   = vld_q && !stall && (Jr || Jal || (Branch && Zero));
    end

    // Next-state and next-PC selection
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        pc_nxt       = pc_q;
        vld_nxt      = vld_q;
        mis_nxt      = mis_q;
        if (!stall) begin
            case (state)
                BOOT, FLUSH: begin
                    // The word read at fetch_pc this cycle becomes real next cycle
                    state_nxt    = RUN;
                    fetch_pc_nxt = fetch_pc + 32'd4;
                    pc_nxt       = fetch_pc;
                    vld_nxt      = 1'b1;
                end
                RUN: begin
                    if (redirect) begin
                        // The sequential word in flight is dropped by clearing valid
                        state_nxt    = FLUSH;
                        fetch_pc_nxt = target;
                        vld_nxt      = 1'b0;
                        if (raw_target[1]) begin
                            mis_nxt = 1'b1;
                        end
                    end else begin
                        fetch_pc_nxt = fetch_pc + 32'd4;
                        pc_nxt       = fetch_pc;
                        vld_nxt      = 1'b1;
                    end
                end
                default: begin
                    state_nxt = BOOT;
                end
            endcase
        end
    end

    // State register; reset overrides stall
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= BOOT;
            fetch_pc <= RESET_PC;
            pc_q     <= RESET_PC;
            vld_q    <= 1'b0;
            mis_q    <= 1'b0;
            held_sel <= 1'b0;
            held_dat <= NOP_INSTR;
        end else begin
            state    <= state_nxt;
            fetch_pc <= fetch_pc_nxt;
            pc_q     <= pc_nxt;
            vld_q    <= vld_nxt;
            mis_q    <= mis_nxt;
            held_sel <= stall;
            if (!held_sel) begin
                held_dat <= imem_rdata;
            end
        end
    end

    // Output drive: ROM address straight from fetch_pc, decode word muxed from ROM or local copy
    always_comb begin
        imem_en     = reset || !stall;
        imem_addr   = fetch_pc[IMEM_AW+1:2];
        instr_valid = vld_q;
        instr_pc    = pc_q;
        link_addr   = pc_q + 32'd4;
        misalign    = mis_q;
        if (!vld_q) begin
            Instruction = NOP_INSTR;
        end else if (held_sel) begin
            Instruction = held_dat;
        end else begin
            Instruction = imem_rdata;
        end
    end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: cycle table with expected outputs queued at drive time and checked late in the cycle.
// A second instance with a high reset PC checks 32-bit wrap of the PC and of the ROM address.
// The bench ROM returns junk after a disabled cycle so the held-word path is exercised.
module tb_ifetch_unit;

    localparam int          AW  = 14;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        rst, stl, br, zr, jl, jr;
        logic [31:0] imm, rd1;
        logic        chk, v, en, mis;
        logic [31:0] pc, ins;
    } vec_t;

    logic          clock;
    logic          reset, stall, br, zr, jal, jr;
    logic [31:0]   imm, rd1;
    logic          imem_en;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_rdata, instruction, instr_pc, link_addr;
    logic          instr_valid, misalign;

    logic          reset_h;
    logic          imem_en_h;
    logic [AW-1:0] imem_addr_h;
    logic [31:0]   imem_rdata_h, instruction_h, instr_pc_h, link_addr_h;
    logic          instr_valid_h, misalign_h;

    int n_cmp = 0;
    int n_bad = 0;

    vec_t tbl[$];
    vec_t exp_q[$];

    ifetch_unit #(.RESET_PC(32'h0000_0000), .IMEM_AW(AW), .NOP_INSTR(NOP)) u_dut (
        .clock(clock), .reset(reset), .stall(stall), .Branch(br), .Zero(zr),
        .Jal(jal), .Jr(jr), .Imm32(imm), .Read_data_1(rd1),
        .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .Instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .link_addr(link_addr), .misalign(misalign)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .IMEM_AW(AW), .NOP_INSTR(NOP)) u_dut_hi (
        .clock(clock), .reset(reset_h), .stall(1'b0), .Branch(1'b0), .Zero(1'b0),
        .Jal(1'b0), .Jr(1'b0), .Imm32(32'h0), .Read_data_1(32'h0),
        .imem_en(imem_en_h), .imem_addr(imem_addr_h), .imem_rdata(imem_rdata_h),
        .Instruction(instruction_h), .instr_pc(instr_pc_h), .instr_valid(instr_valid_h),
        .link_addr(link_addr_h), .misalign(misalign_h)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM content: word i holds i+1
    function automatic logic [31:0] rom_val(input logic [AW-1:0] a);
        return {{(32-AW){1'b0}}, a} + 32'd1;
    endfunction

    always @(posedge clock) begin
        imem_rdata   <= imem_en   ? rom_val(imem_addr)   : 32'hDEAD_BEEF;
        imem_rdata_h <= imem_en_h ? rom_val(imem_addr_h) : 32'hDEAD_BEEF;
    end

    task automatic cmp(input string name, input int row, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s row %0d: got %h, want %h", name, row, act, want);
        end
    endtask

    function automatic vec_t mk(input logic rst, stl, b, z, jl, j,
                                input logic [31:0] im, r1,
                                input logic chk, v, en, mis,
                                input logic [31:0] pc, ins);
        vec_t t;
        t.rst = rst; t.stl = stl; t.br = b; t.zr = z; t.jl = jl; t.jr = j;
        t.imm = im; t.rd1 = r1;
        t.chk = chk; t.v = v; t.en = en; t.mis = mis; t.pc = pc; t.ins = ins;
        return t;
    endfunction

    initial begin
        vec_t e;
        reset = 1'b1; stall = 1'b0; br = 1'b0; zr = 1'b0; jal = 1'b0; jr = 1'b0;
        imm = 32'h0; rd1 = 32'h0; reset_h = 1'b1;

        //               rst stl br zr jl jr imm           rd1         chk v en mis pc          ins
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,      0, 0, 1, 0, 32'h0,      NOP));     // 0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 0, 32'h0,      NOP));     // 1 reset state
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 0, 32'h0,      NOP));     // 2 BOOT
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 0, 32'h0,      32'h1));   // 3
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 0, 32'h4,      32'h2));   // 4
        tbl.push_back(mk(0, 0, 1, 1, 0, 0, 32'd16,       32'h0,      1, 1, 1, 0, 32'h8,      32'h3));   // 5 taken branch
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 0, 32'h0,      NOP));     // 6 bubble
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 0, 32'd24,     32'h7));   // 7
        tbl.push_back(mk(0, 0, 1, 0, 0, 0, 32'd16,       32'h0,      1, 1, 1, 0, 32'd28,     32'h8));   // 8 not taken
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1,        32'h103,    1, 1, 1, 0, 32'd32,     32'h9));   // 9 jalr aligned
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 0, 32'h0,      NOP));     // 10
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h3,        32'h103,    1, 1, 1, 0, 32'h104,    32'h42));  // 11 jalr misaligned
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 1, 32'h0,      NOP));     // 12
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 1, 32'h104,    32'h42));  // 13
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'hFFFF_FEF8, 32'h0,     1, 1, 1, 1, 32'h108,    32'h43));  // 14 jal wraps to 0
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 1, 32'h0,      NOP));     // 15
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 1, 32'h0,      32'h1));   // 16
        tbl.push_back(mk(0, 1, 1, 1, 0, 0, 32'd100,      32'h0,      1, 1, 0, 1, 32'h4,      32'h2));   // 17 stall + branch
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 32'h0,        32'h200,    1, 1, 0, 1, 32'h4,      32'h2));   // 18 stall + jump
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 0, 1, 32'h4,      32'h2));   // 19
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 1, 32'h4,      32'h2));   // 20 release
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 1, 32'h8,      32'h3));   // 21
        tbl.push_back(mk(0, 0, 0, 0, 1, 0, 32'h20,       32'h0,      1, 1, 1, 1, 32'd12,     32'h4));   // 22 jal
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 1, 32'h0,      NOP));     // 23 reset in FLUSH
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 0, 1, 0, 32'h0,      NOP));     // 24 BOOT again
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 0, 32'h0,      32'h1));   // 25
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,      1, 1, 1, 0, 32'h4,      32'h2));   // 26

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            reset = tbl[i].rst; stall = tbl[i].stl; br = tbl[i].br; zr = tbl[i].zr;
            jal = tbl[i].jl; jr = tbl[i].jr; imm = tbl[i].imm; rd1 = tbl[i].rd1;
            exp_q.push_back(tbl[i]);
            #4;
            e = exp_q.pop_front();
            if (e.chk) begin
                cmp("instr_valid", i, {31'h0, instr_valid}, {31'h0, e.v});
                cmp("imem_en",     i, {31'h0, imem_en},     {31'h0, e.en});
                cmp("misalign",    i, {31'h0, misalign},    {31'h0, e.mis});
                cmp("Instruction", i, instruction,          e.ins);
                if (e.v) begin
                    cmp("instr_pc",  i, instr_pc,  e.pc);
                    cmp("link_addr", i, link_addr, e.pc + 32'd4);
                end
            end
        end
        reset = 1'b0; stall = 1'b0; br = 1'b0; zr = 1'b0; jal = 1'b0; jr = 1'b0;

        // High reset PC: sequence FFFF_FFF8, FFFF_FFFC, 0 with ROM address wrapping
        @(negedge clock);
        reset_h = 1'b0;
        #4;
        cmp("hi boot valid", 0, {31'h0, instr_valid_h}, 32'h0);
        cmp("hi boot addr",  0, {18'h0, imem_addr_h},   32'h3FFE);
        cmp("hi boot instr", 0, instruction_h,          NOP);
        @(negedge clock); #4;
        cmp("hi pc",    1, instr_pc_h,    32'hFFFF_FFF8);
        cmp("hi instr", 1, instruction_h, 32'h3FFF);
        cmp("hi addr",  1, {18'h0, imem_addr_h}, 32'h3FFF);
        @(negedge clock); #4;
        cmp("hi pc",    2, instr_pc_h,    32'hFFFF_FFFC);
        cmp("hi instr", 2, instruction_h, 32'h4000);
        cmp("hi link",  2, link_addr_h,   32'h0);
        cmp("hi addr",  2, {18'h0, imem_addr_h}, 32'h0);
        @(negedge clock); #4;
        cmp("hi pc",    3, instr_pc_h,    32'h0);
        cmp("hi instr", 3, instruction_h, 32'h1);
        cmp("hi valid", 3, {31'h0, instr_valid_h}, 32'h1);
        cmp("hi misalign", 3, {31'h0, misalign_h}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
